lanzones_fetch: RTL and testbench
=================================

Name: lanzones_fetch

Overview:
Instruction fetch stage of the lanzones core. It sits directly upstream of the memory model's read port: it drives RRdy/RAddr, consumes RVld/RData, and buffers fetched words with their PC in a 2-entry queue that feeds decode over a valid/ready handshake. It supports PC redirects from execute, a halt request, and a start pulse (LEn).

Parameters:
RESET_PC, 32'h0000_0400, byte PC loaded on LEn
ADDR_SHIFT, 2, right shift from byte PC to word address driven on RAddr
QDEPTH, 2, instruction queue depth; fixed at 2, other values unsupported

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
LEn  in  1  start pulse; loads RESET_PC and starts fetching
RRdy  out  1  read request to memory; memory samples it each posedge
RAddr  out  32  word address, PC >> ADDR_SHIFT, zero-extended
RVld  in  1  read response valid; RData is valid in the same cycle
RData  in  32  read response data
IVld  out  1  head of queue valid to decode
IRdy  in  1  decode accepts head when IVld && IRdy
IData  out  32  instruction word at head
IPc  out  32  byte PC of head
RedirVld  in  1  redirect request (branch/jump)
RedirPc  in  32  redirect target byte PC; bits [1:0] ignored, forced to 0
HaltReq  in  1  stop fetching (decode saw halt)
Busy  out  1  high in RUN, or while a request is outstanding

Behaviour:
- Reset (rst=1 at posedge): state IDLE, pc=0, queue empty, outstanding=0, drop=0. Outputs read RRdy=0, RAddr=0, IVld=0, IData=0, IPc=0, Busy=0. Reset mid-transaction abandons everything. A response arriving in the cycle after reset is ignored.
- FSM states:
  - IDLE: on LEn, pc<=RESET_PC and go to RUN.
  - RUN: HaltReq goes to HALTED.
  - HALTED: LEn reloads RESET_PC, flushes the queue, and goes to RUN.
- Memory protocol: at most one request outstanding. Each request is answered exactly one cycle later.
- Issue rule: RRdy=1 iff state==RUN, !outstanding, !HaltReq, !RedirVld, and (count + outstanding) < 2.
  - RRdy is a single-cycle pulse.
  - The issue cycle sets outstanding=1 and latches req_pc=pc, then pc<=pc+4 (wraps mod 2^32).
  - Peak throughput is 1 word per 2 cycles.
- RAddr = pc >> ADDR_SHIFT while RRdy=1. It holds its last value otherwise.
- Response: RVld with outstanding clears outstanding.
  - If !drop: push {RData, req_pc} into the queue.
  - If drop: discard the response and clear drop.
  - RVld without outstanding is ignored.
- Queue:
  - 2 entries, head registered onto IData/IPc/IVld.
  - Pop on IVld && IRdy.
  - Push and pop in the same cycle is allowed when full.
  - A push can never overflow, guaranteed by the issue rule.
- Redirect (RedirVld=1, any state except IDLE):
  - pc<=RedirPc&~3.
  - Queue flushed, count=0; IVld=0 next cycle.
  - If a request is outstanding, drop<=1.
  - If RedirVld coincides with RVld, that response is discarded.
  - The first fetch of the target is issued in the cycle after the redirect.
- Redirect and pop in the same cycle: the redirect wins and the pop is a no-op.
- Redirect and HaltReq in the same cycle: the pc is updated and the FSM goes to HALTED.
- HaltReq:
  - No new RRdy.
  - An outstanding response still lands in the queue, and the queue keeps draining to decode.
- LEn in RUN is ignored.
- Busy = (state==RUN) || outstanding.

Decomposition:
- Shared package lanzones_pkg: RESET_PC default, ADDR_SHIFT, fetch FSM state encoding (IDLE=0, RUN=1, HALTED=2), and the 64-bit queue entry layout {pc, instr}.
- One sub-module: lanzones_fetch_q, a 2-entry synchronous FIFO with flush, push, pop, count, and head outputs.

Test Plan:
- Reset, then LEn. Memory holds 0x11,0x22,0x33 at words 0x100..0x102, IRdy=1.
  -> RRdy pulses with RAddr 0x100, 0x101, 0x102 every 2nd cycle.
  -> IData 0x11/IPc 0x400, 0x22/0x404, 0x33/0x408, in order.
- IRdy=0 after LEn.
  -> Exactly 2 requests are issued, then RRdy stays 0 with count=2.
  -> Raising IRdy drains 0x11 then 0x22; fetching resumes at RAddr 0x102.
- RedirVld with RedirPc=0x0000_0803 in the cycle RVld returns word 0x101.
  -> That word is dropped and the queue is flushed.
  -> Next RRdy has RAddr 0x200; the first IPc is 0x800.
- HaltReq while a request is outstanding.
  -> The response is still delivered and no further RRdy is issued.
  -> Busy falls after the queue response; LEn restarts fetching at RAddr 0x100.
- rst=1 for 1 cycle while outstanding.
  -> All outputs return to 0 and the late RVld is ignored.
  -> IVld stays 0 until LEn.
- RESET_PC=0xFFFF_FFFC, fetching 2 words.
  -> RAddr 0x3FFF_FFFF, then 0x0000_0000 (pc wraps to 0).

Source files
------------

// File: rtl/lanzones_pkg.sv
// Shared definitions for the lanzones instruction fetch stage.
// Contents: default reset PC, PC-to-word-address shift, fetch FSM state
// encoding, and the 64-bit instruction queue entry layout {pc, instr}.
package lanzones_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0400;
  localparam int          ADDR_SHIFT_DEF = 2;
  localparam int          QDEPTH_DEF     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } qentry_t;

  // Instructions are word aligned; the low two PC bits are never meaningful.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lanzones_fetch_q.sv
// Two-entry instruction queue between fetch and decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the queue; wins over push and pop
//   push, push_data write one entry at the tail
//   pop             removes the head (ignored when empty)
//   count           number of valid entries (0..2)
//   head_vld, head  registered head entry
module lanzones_fetch_q
  import lanzones_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  qentry_t    push_data,
  input  logic       pop,
  output logic [1:0] count,
  output logic       head_vld,
  output qentry_t    head
);

  qentry_t    e0;
  qentry_t    e1;
  logic [1:0] cnt;
  logic       pop_ok;

  assign pop_ok = pop && (cnt != 2'd0);

  // e0 is always the head, so the head outputs come straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count    = cnt;
  assign head_vld = (cnt != 2'd0);
  assign head     = e0;

endmodule

// File: rtl/lanzones_fetch.sv
// Instruction fetch stage of the lanzones core.
// Issues single-word reads to memory (one outstanding, answered one cycle
// later), buffers responses with their PC in a 2-entry queue and hands them
// to decode over IVld/IRdy. Supports redirects, halt and restart.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   LEn                  start pulse, loads RESET_PC
//   RRdy, RAddr          read request and word address to memory
//   RVld, RData          read response from memory
//   IVld, IRdy, IData, IPc  queue head to decode
//   RedirVld, RedirPc    redirect from execute
//   HaltReq              stop issuing new requests
//   Busy                 running, or a request still outstanding
//
// state     | meaning
// ST_IDLE   | after reset, waiting for LEn
// ST_RUN    | fetching
// ST_HALTED | halted; outstanding response still delivered, LEn restarts
module lanzones_fetch
  import lanzones_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          ADDR_SHIFT = ADDR_SHIFT_DEF,
  parameter int          QDEPTH     = QDEPTH_DEF   // only 2 is supported
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        LEn,
  output logic        RRdy,
  output logic [31:0] RAddr,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic        IVld,
  input  logic        IRdy,
  output logic [31:0] IData,
  output logic [31:0] IPc,
  input  logic        RedirVld,
  input  logic [31:0] RedirPc,
  input  logic        HaltReq,
  output logic        Busy
);

  localparam logic [2:0] QD = 3'(QDEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  req_pc;
  logic [31:0]  raddr_q;
  logic         outstanding, outstanding_nxt;
  logic         drop, drop_nxt;

  logic         redir, restart, rsp, issue, flush, push, pop;
  logic [1:0]   q_count;
  logic [2:0]   inflight;
  logic         q_vld;
  qentry_t      q_head;
  qentry_t      q_in;
  logic [31:0]  pc_word;

  assign pc_word  = pc >> ADDR_SHIFT;
  assign inflight = {1'b0, q_count} + {2'b00, outstanding};

  assign redir   = RedirVld && (state != ST_IDLE);
  assign restart = LEn && (state == ST_HALTED);
  assign rsp     = RVld && outstanding;
  assign issue   = (state == ST_RUN) && !outstanding && !HaltReq && !RedirVld
                   && (inflight < QD);
  assign flush   = redir || restart;
  // A response that meets a redirect/restart belongs to the old stream.
  assign push    = rsp && !drop && !flush;
  assign pop     = q_vld && IRdy && !flush;
  assign q_in    = '{pc: req_pc, instr: RData};

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    outstanding_nxt = outstanding;
    drop_nxt        = drop;

    case (state)
      ST_IDLE: begin
        if (LEn) begin
          state_nxt = ST_RUN;
          pc_nxt    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (HaltReq) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (LEn) begin
          state_nxt = ST_RUN;
          pc_nxt    = RESET_PC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (issue) begin
      pc_nxt          = pc + 32'd4;
      outstanding_nxt = 1'b1;
    end else if (rsp) begin
      outstanding_nxt = 1'b0;
    end

    if (rsp) drop_nxt = 1'b0;

    if (redir) pc_nxt = word_align(RedirPc);

    // A request still in flight when the stream changes must be discarded on
    // arrival; if it arrives this very cycle it is already discarded above.
    if (flush) drop_nxt = outstanding && !RVld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      req_pc      <= '0;
      raddr_q     <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      if (issue) begin
        req_pc  <= pc;
        raddr_q <= pc_word;
      end
    end
  end

  lanzones_fetch_q u_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .count     (q_count),
    .head_vld  (q_vld),
    .head      (q_head)
  );

  assign RRdy  = issue;
  assign RAddr = issue ? pc_word : raddr_q;
  assign IVld  = q_vld;
  assign IData = q_head.instr;
  assign IPc   = q_head.pc;
  assign Busy  = (state == ST_RUN) || outstanding;

endmodule

// File: tb/tb_lanzones_fetch.sv
module tb_lanzones_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LEn = 1'b0;
  logic        RRdy;
  logic [31:0] RAddr;
  logic        RVld = 1'b0;
  logic [31:0] RData = '0;
  logic        IVld;
  logic        IRdy = 1'b0;
  logic [31:0] IData;
  logic [31:0] IPc;
  logic        RedirVld = 1'b0;
  logic [31:0] RedirPc = '0;
  logic        HaltReq = 1'b0;
  logic        Busy;

  logic        w_LEn = 1'b0;
  logic        w_RRdy;
  logic [31:0] w_RAddr;
  logic        w_RVld = 1'b0;
  logic [31:0] w_RData = '0;
  logic        w_IVld;
  logic [31:0] w_IData;
  logic [31:0] w_IPc;
  logic        w_Busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lanzones_fetch u_dut (
    .clk(clk), .rst(rst), .LEn(LEn), .RRdy(RRdy), .RAddr(RAddr),
    .RVld(RVld), .RData(RData), .IVld(IVld), .IRdy(IRdy), .IData(IData),
    .IPc(IPc), .RedirVld(RedirVld), .RedirPc(RedirPc), .HaltReq(HaltReq),
    .Busy(Busy)
  );

  lanzones_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_w (
    .clk(clk), .rst(rst), .LEn(w_LEn), .RRdy(w_RRdy), .RAddr(w_RAddr),
    .RVld(w_RVld), .RData(w_RData), .IVld(w_IVld), .IRdy(1'b1), .IData(w_IData),
    .IPc(w_IPc), .RedirVld(1'b0), .RedirPc(32'h0), .HaltReq(1'b0),
    .Busy(w_Busy)
  );

  typedef struct {
    logic        rst, len, irdy, halt;
    logic        e_rrdy;
    logic [31:0] e_raddr;
    logic        e_ivld;
    logic [31:0] e_idata, e_ipc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, len, irdy, halt, err,
                              input logic [31:0] ea, input logic eiv,
                              input logic [31:0] ed, ep, input logic eb);
    vec_t v;
    v.rst = r; v.len = len; v.irdy = irdy; v.halt = halt;
    v.e_rrdy = err; v.e_raddr = ea; v.e_ivld = eiv;
    v.e_idata = ed; v.e_ipc = ep; v.e_busy = eb;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h101: return 32'h22;
      32'h102: return 32'h33;
      32'h200: return 32'h44;
      default: return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: a request seen at a posedge is answered in the next cycle.
  task automatic tick();
    logic        req;
    logic [31:0] a;
    #1;
    req = (RRdy === 1'b1);
    a   = RAddr;
    @(posedge clk);
    #1;
    RVld  = req;
    RData = req ? mem_word(a) : 32'h0;
  endtask

  task automatic do_reset();
    LEn = 0; HaltReq = 0; RedirVld = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // normal streaming, IRdy=1
    vecs.push_back(mk(1,0,1,0, 0,32'h0,   0,32'h0, 32'h0,   0));
    vecs.push_back(mk(0,1,1,0, 0,32'h0,   0,32'h0, 32'h0,   0));
    vecs.push_back(mk(0,0,1,0, 1,32'h100, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,1,0, 0,32'h100, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,1,0, 1,32'h101, 1,32'h11,32'h400, 1));
    vecs.push_back(mk(0,0,1,0, 0,32'h101, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,1,0, 1,32'h102, 1,32'h22,32'h404, 1));
    vecs.push_back(mk(0,0,1,0, 0,32'h102, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,1,1, 0,32'h102, 1,32'h33,32'h408, 1));
    vecs.push_back(mk(0,0,1,0, 0,32'h102, 0,32'h0, 32'h0,   0));
    // backpressure, IRdy=0 until queue is full
    vecs.push_back(mk(1,0,0,0, 0,32'h0,   0,32'h0, 32'h0,   0));
    vecs.push_back(mk(0,1,0,0, 0,32'h0,   0,32'h0, 32'h0,   0));
    vecs.push_back(mk(0,0,0,0, 1,32'h100, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,0,0, 0,32'h100, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,0,0, 1,32'h101, 1,32'h11,32'h400, 1));
    vecs.push_back(mk(0,0,0,0, 0,32'h101, 1,32'h11,32'h400, 1));
    vecs.push_back(mk(0,0,0,0, 0,32'h101, 1,32'h11,32'h400, 1));
    vecs.push_back(mk(0,0,0,0, 0,32'h101, 1,32'h11,32'h400, 1));
    vecs.push_back(mk(0,0,1,0, 0,32'h101, 1,32'h11,32'h400, 1));
    vecs.push_back(mk(0,0,1,0, 1,32'h102, 1,32'h22,32'h404, 1));
    vecs.push_back(mk(0,0,1,0, 0,32'h102, 0,32'h0, 32'h0,   1));
    vecs.push_back(mk(0,0,1,1, 0,32'h102, 1,32'h33,32'h408, 1));
    vecs.push_back(mk(0,0,1,0, 0,32'h102, 0,32'h0, 32'h0,   0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      LEn = v.len; IRdy = v.irdy; HaltReq = v.halt; RedirVld = 0;
      if (v.rst) begin
        rst = 1;
        tick();
        rst = 0;
      end
      #1;
      chk($sformatf("v%0d_rrdy", i),  32'(RRdy),  32'(v.e_rrdy));
      chk($sformatf("v%0d_raddr", i), RAddr,      v.e_raddr);
      chk($sformatf("v%0d_ivld", i),  32'(IVld),  32'(v.e_ivld));
      chk($sformatf("v%0d_busy", i),  32'(Busy),  32'(v.e_busy));
      if (v.e_ivld || v.rst) begin
        chk($sformatf("v%0d_idata", i), IData, v.e_idata);
        chk($sformatf("v%0d_ipc", i),   IPc,   v.e_ipc);
      end
      if (!v.rst) tick();
    end

    // redirect coinciding with the response for word 0x101
    IRdy = 0;
    do_reset();
    LEn = 1; tick(); LEn = 0;
    #1; chk("rd_rrdy0", 32'(RRdy), 1); chk("rd_raddr0", RAddr, 32'h100);
    tick();
    tick();
    #1; chk("rd_ivld1", 32'(IVld), 1); chk("rd_idata1", IData, 32'h11);
    chk("rd_rrdy1", 32'(RRdy), 1); chk("rd_raddr1", RAddr, 32'h101);
    tick();
    RedirVld = 1; RedirPc = 32'h0000_0803;
    #1; chk("rd_rrdy_redir", 32'(RRdy), 0);
    tick();
    RedirVld = 0;
    #1; chk("rd_ivld_flush", 32'(IVld), 0); chk("rd_rrdy2", 32'(RRdy), 1);
    chk("rd_raddr2", RAddr, 32'h200);
    tick();
    #1; chk("rd_ivld_wait", 32'(IVld), 0);
    tick();
    #1; chk("rd_ivld3", 32'(IVld), 1); chk("rd_ipc3", IPc, 32'h800);
    chk("rd_idata3", IData, 32'h44);

    // halt while a request is outstanding
    IRdy = 1;
    do_reset();
    LEn = 1; tick(); LEn = 0;
    #1; chk("ht_rrdy0", 32'(RRdy), 1); chk("ht_raddr0", RAddr, 32'h100);
    tick();
    HaltReq = 1;
    #1; chk("ht_rrdy1", 32'(RRdy), 0); chk("ht_busy1", 32'(Busy), 1);
    tick();
    HaltReq = 0;
    #1; chk("ht_ivld", 32'(IVld), 1); chk("ht_idata", IData, 32'h11);
    chk("ht_ipc", IPc, 32'h400); chk("ht_busy2", 32'(Busy), 0);
    chk("ht_rrdy2", 32'(RRdy), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1; chk($sformatf("ht_idle_rrdy%0d", k), 32'(RRdy), 0);
      tick();
    end
    LEn = 1; tick(); LEn = 0;
    #1; chk("ht_restart_rrdy", 32'(RRdy), 1); chk("ht_restart_raddr", RAddr, 32'h100);
    chk("ht_restart_busy", 32'(Busy), 1);
    tick();

    // reset while outstanding, then a stray response right after reset
    rst = 1;
    tick();
    rst = 0;
    RVld = 1; RData = 32'h99;
    #1; chk("rs_rrdy", 32'(RRdy), 0); chk("rs_raddr", RAddr, 32'h0);
    chk("rs_ivld", 32'(IVld), 0); chk("rs_idata", IData, 32'h0);
    chk("rs_ipc", IPc, 32'h0); chk("rs_busy", 32'(Busy), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1; chk($sformatf("rs_ivld_hold%0d", k), 32'(IVld), 0);
      chk($sformatf("rs_busy_hold%0d", k), 32'(Busy), 0);
      tick();
    end
    LEn = 1; tick(); LEn = 0;
    #1; chk("rs_len_rrdy", 32'(RRdy), 1); chk("rs_len_raddr", RAddr, 32'h100);
    tick();

    // PC wrap from 0xFFFF_FFFC
    do_reset();
    w_LEn = 1; tick(); w_LEn = 0;
    #1; chk("wr_rrdy0", 32'(w_RRdy), 1); chk("wr_raddr0", w_RAddr, 32'h3FFF_FFFF);
    tick();
    w_RVld = 1; w_RData = 32'hAAAA_0001;
    #1; chk("wr_rrdy_busy", 32'(w_RRdy), 0);
    tick();
    w_RVld = 0;
    #1; chk("wr_ivld", 32'(w_IVld), 1); chk("wr_ipc", w_IPc, 32'hFFFF_FFFC);
    chk("wr_idata", w_IData, 32'hAAAA_0001);
    chk("wr_rrdy1", 32'(w_RRdy), 1); chk("wr_raddr1", w_RAddr, 32'h0000_0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
